// File: rtl/aes_axi_pkg.sv
// Shared definitions for the AES accelerator register map and the AXI4-Lite
// host sequencer: register offsets, bit positions, response and error codes,
// the sequencer state type and the write-index to register-offset mapping.
package aes_axi_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_MODE   = 32'h08;
  localparam logic [31:0] OFF_KEY0   = 32'h0C;
  localparam logic [31:0] OFF_DIN0   = 32'h40;
  localparam logic [31:0] OFF_DOUT0  = 32'h80;

  localparam int CTRL_START  = 0;
  localparam int STATUS_DONE = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Index of the final setup write (ctrl = start).
  localparam logic [3:0] WR_LAST = 4'd13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_POLL_AR,
    S_POLL_R,
    S_RD_AR,
    S_RD_R,
    S_CLR,
    S_CLR_B,
    S_RSP
  } state_t;

  // Setup write index: 0 mode, 1..8 key[0..7], 9..12 data_in[0..3], 13 ctrl.
  function automatic logic [31:0] wr_offset(input logic [3:0] idx);
    logic [3:0] w;
    if (idx == 4'd0) begin
      return OFF_MODE;
    end else if (idx <= 4'd8) begin
      w = idx - 4'd1;
      return OFF_KEY0 + {26'd0, w, 2'b00};
    end else if (idx <= 4'd12) begin
      w = idx - 4'd9;
      return OFF_DIN0 + {26'd0, w, 2'b00};
    end else begin
      return OFF_CTRL;
    end
  endfunction

endpackage

// File: rtl/axil_single_write.sv
// Single AXI4-Lite write engine. A one-cycle start pulse latches addr/data and
// raises AWVALID and WVALID together; each drops independently on its own
// READY. Once both are accepted BREADY is held until BVALID.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start, addr, data    launch a write with this address / data word
//   accepted             comb: both AW and W are done this cycle
//   done, err            comb: B handshake this cycle / with non-OKAY BRESP
//   m_aw*, m_w*, m_b*    AXI4-Lite write channels
module axil_single_write
  import aes_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        accepted,
  output logic        done,
  output logic        err,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp
);

  assign m_wstrb = 4'hF;

  // The channel still pending (if any) is the one that completes this cycle.
  assign accepted = (m_awvalid | m_wvalid) &
                    (~m_awvalid | m_awready) &
                    (~m_wvalid | m_wready);
  assign done = m_bready & m_bvalid;
  assign err  = done & (m_bresp != RESP_OKAY);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
    end else begin
      if (start) begin
        m_awvalid <= 1'b1;
        m_wvalid  <= 1'b1;
        m_awaddr  <= addr;
        m_wdata   <= data;
      end else begin
        if (m_awready) m_awvalid <= 1'b0;
        if (m_wready)  m_wvalid  <= 1'b0;
      end
      if (accepted) m_bready <= 1'b1;
      else if (done) m_bready <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_axil_host_seq.sv
// AXI4-Lite initiator running one AES job on the accelerator register slave:
// writes mode, key, data_in and start, polls status until done, reads four
// data_out words, always clears ctrl, then returns the result.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | waiting for a command (cmd_ready = 1)
//   S_WR      | setup write idx: AW/W outstanding
//   S_WR_B    | setup write idx: waiting for B
//   S_POLL_AR | status read address
//   S_POLL_R  | status read data, count polls
//   S_RD_AR   | data_out[rd_idx] read address
//   S_RD_R    | data_out[rd_idx] read data
//   S_CLR     | ctrl = 0 write: AW/W outstanding
//   S_CLR_B   | ctrl = 0 write: waiting for B
//   S_RSP     | result presented until rsp_ready
//
// Ports: clk/resetn (sync active-low); cmd_* request (key, data, mode);
// rsp_* result (data, err: 00 ok, 01 bus, 10 timeout); m_* AXI4-Lite master.
module aes_axil_host_seq
  import aes_axi_pkg::*;
#(
  parameter int          POLL_MAX  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_data,
  input  logic [31:0]  cmd_mode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic [1:0]   rsp_err,
  output logic         m_awvalid,
  input  logic         m_awready,
  output logic [31:0]  m_awaddr,
  output logic         m_wvalid,
  input  logic         m_wready,
  output logic [31:0]  m_wdata,
  output logic [3:0]   m_wstrb,
  input  logic         m_bvalid,
  output logic         m_bready,
  input  logic [1:0]   m_bresp,
  output logic         m_arvalid,
  input  logic         m_arready,
  output logic [31:0]  m_araddr,
  input  logic         m_rvalid,
  output logic         m_rready,
  input  logic [31:0]  m_rdata,
  input  logic [1:0]   m_rresp
);

  localparam logic [31:0] POLL_LIM = 32'(POLL_MAX);
  localparam logic [31:0] CTRL_GO  = 32'h1 << CTRL_START;

  state_t           state, state_nxt;
  logic [3:0]       idx, idx_nxt, idx_p1;
  logic [1:0]       rd_idx, rd_nxt;
  logic [31:0]      poll_cnt, poll_nxt;
  logic [1:0]       err, err_nxt;
  logic [7:0][31:0] key_r;
  logic [3:0][31:0] data_r;
  logic [3:0][31:0] result, result_nxt;

  logic        wr_start, wr_accepted, wr_done, wr_err;
  logic [31:0] wr_addr, wr_data;
  logic        cmd_fire;

  assign cmd_ready = (state == S_IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_valid = (state == S_RSP);
  assign rsp_err   = err;
  assign rsp_data  = (err == ERR_OK) ? result : '0;
  assign idx_p1    = idx + 4'd1;

  axil_single_write u_wr (
    .clk       (clk),
    .resetn    (resetn),
    .start     (wr_start),
    .addr      (wr_addr),
    .data      (wr_data),
    .accepted  (wr_accepted),
    .done      (wr_done),
    .err       (wr_err),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      idx      <= '0;
      rd_idx   <= '0;
      poll_cnt <= '0;
      err      <= ERR_OK;
      key_r    <= '0;
      data_r   <= '0;
      result   <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      rd_idx   <= rd_nxt;
      poll_cnt <= poll_nxt;
      err      <= err_nxt;
      result   <= result_nxt;
      if (cmd_fire) begin
        key_r  <= cmd_key;
        data_r <= cmd_data;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rd_nxt     = rd_idx;
    poll_nxt   = poll_cnt;
    err_nxt    = err;
    result_nxt = result;
    wr_start   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_rready   = 1'b0;
    unique case (state)
      S_IDLE: begin
        // The mode write launches straight from the command port; the engine
        // holds the word, so mode needs no separate capture register.
        if (cmd_valid) begin
          state_nxt = S_WR;
          idx_nxt   = '0;
          err_nxt   = ERR_OK;
          wr_start  = 1'b1;
          wr_addr   = BASE_ADDR + OFF_MODE;
          wr_data   = cmd_mode;
        end
      end
      S_WR: if (wr_accepted) state_nxt = S_WR_B;
      S_WR_B: begin
        if (wr_done) begin
          if (wr_err) begin
            err_nxt   = ERR_BUS;
            state_nxt = S_CLR;
            wr_start  = 1'b1;
            wr_addr   = BASE_ADDR + OFF_CTRL;
          end else if (idx == WR_LAST) begin
            state_nxt = S_POLL_AR;
            poll_nxt  = '0;
          end else begin
            idx_nxt   = idx_p1;
            state_nxt = S_WR;
            wr_start  = 1'b1;
            wr_addr   = BASE_ADDR + wr_offset(idx_p1);
            if (idx_p1 <= 4'd8)       wr_data = key_r[3'(idx_p1 - 4'd1)];
            else if (idx_p1 <= 4'd12) wr_data = data_r[2'(idx_p1 - 4'd9)];
            else                      wr_data = CTRL_GO;
          end
        end
      end
      S_POLL_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = BASE_ADDR + OFF_STATUS;
        if (m_arready) state_nxt = S_POLL_R;
      end
      S_POLL_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          poll_nxt = poll_cnt + 32'd1;
          if (m_rresp != RESP_OKAY || (!m_rdata[STATUS_DONE] && poll_nxt == POLL_LIM)) begin
            err_nxt   = (m_rresp != RESP_OKAY) ? ERR_BUS : ERR_TIMEOUT;
            state_nxt = S_CLR;
            wr_start  = 1'b1;
            wr_addr   = BASE_ADDR + OFF_CTRL;
          end else if (m_rdata[STATUS_DONE]) begin
            state_nxt = S_RD_AR;
            rd_nxt    = '0;
          end else begin
            state_nxt = S_POLL_AR;
          end
        end
      end
      S_RD_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = BASE_ADDR + OFF_DOUT0 + {28'd0, rd_idx, 2'b00};
        if (m_arready) state_nxt = S_RD_R;
      end
      S_RD_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          if (m_rresp != RESP_OKAY) begin
            err_nxt   = ERR_BUS;
            state_nxt = S_CLR;
            wr_start  = 1'b1;
            wr_addr   = BASE_ADDR + OFF_CTRL;
          end else begin
            result_nxt[rd_idx] = m_rdata;
            if (rd_idx == 2'd3) begin
              state_nxt = S_CLR;
              wr_start  = 1'b1;
              wr_addr   = BASE_ADDR + OFF_CTRL;
            end else begin
              rd_nxt    = rd_idx + 2'd1;
              state_nxt = S_RD_AR;
            end
          end
        end
      end
      S_CLR: if (wr_accepted) state_nxt = S_CLR_B;
      S_CLR_B: begin
        if (wr_done) begin
          // Keep the first error; a failing clear only reports if all else was ok.
          if (wr_err && err == ERR_OK) err_nxt = ERR_BUS;
          state_nxt = S_RSP;
        end
      end
      S_RSP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_axil_host_seq.sv
// Bench for aes_axil_host_seq: an AXI4-Lite slave model of the accelerator
// with random ready delays, error injection and a configurable done poll,
// checked against the job's expected bus traffic and result.
module tb_aes_axil_host_seq;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          PMAX = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         cmd_valid, cmd_ready;
  logic [255:0] cmd_key;
  logic [127:0] cmd_data;
  logic [31:0]  cmd_mode;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_err;
  logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]   m_wstrb;
  logic [1:0]   m_bresp, m_rresp;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;

  always #5 clk = ~clk;

  aes_axil_host_seq #(.POLL_MAX(PMAX), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_data(cmd_data), .cmd_mode(cmd_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          cfg_done_on, cfg_dly_max;
  bit          cfg_err_en;
  logic [31:0] cfg_err_addr;
  logic [63:0] wlog[$];
  logic [31:0] rlog[$];
  logic [31:0] s_key[8];
  logic [31:0] s_din[4];
  logic [31:0] s_mode;
  int          s_status_rds, viol;
  int          aw_dly, w_dly, ar_dly;
  bit          aw_have, w_have, b_pend, r_pend, aw_seen, w_seen;
  logic [31:0] aw_q, w_q, aw_seen_v, w_seen_v, r_q;
  logic [1:0]  b_q;

  function automatic int rnd_dly();
    return (cfg_dly_max == 0) ? 0 : int'($urandom_range(cfg_dly_max, 0));
  endfunction

  task automatic slave_clear();
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0; aw_seen = 0; w_seen = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
  endtask

  task automatic slave_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off = a - BASE;
    if (off == 32'h08) s_mode = d;
    else if (off >= 32'h0C && off <= 32'h28) s_key[(off - 32'h0C) >> 2] = d;
    else if (off >= 32'h40 && off <= 32'h4C) s_din[(off - 32'h40) >> 2] = d;
  endtask

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    logic [31:0] off, junk;
    int          i;
    off = a - BASE;
    if (off == 32'h04) begin
      s_status_rds++;
      junk = $urandom();
      junk[0] = (cfg_done_on != 0 && s_status_rds >= cfg_done_on);
      return junk;
    end else if (off >= 32'h80 && off <= 32'h8C) begin
      i = int'((off - 32'h80) >> 2);
      return s_din[i] ^ s_key[i] ^ s_key[i+4] ^ s_mode;
    end
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!resetn) slave_clear();
      else begin
        m_bvalid = 0;
        if (b_pend) begin
          m_bvalid = 1; m_bresp = b_q;
          if (m_bready) b_pend = 0;
        end
        m_rvalid = 0;
        if (r_pend) begin
          m_rvalid = 1; m_rdata = r_q; m_rresp = 0;
          if (m_rready) r_pend = 0;
        end
        if (m_arvalid && (m_awvalid || m_wvalid || m_bready)) viol++;
        m_awready = 0;
        if (m_awvalid) begin
          if (aw_have || b_pend) viol++;
          if (aw_seen && m_awaddr !== aw_seen_v) viol++;
          if (aw_dly == 0) begin
            m_awready = 1; aw_have = 1; aw_q = m_awaddr; aw_seen = 0; aw_dly = rnd_dly();
          end else begin
            aw_dly--; aw_seen = 1; aw_seen_v = m_awaddr;
          end
        end else aw_seen = 0;
        m_wready = 0;
        if (m_wvalid) begin
          if (w_have || b_pend || m_wstrb !== 4'hF) viol++;
          if (w_seen && m_wdata !== w_seen_v) viol++;
          if (w_dly == 0) begin
            m_wready = 1; w_have = 1; w_q = m_wdata; w_seen = 0; w_dly = rnd_dly();
          end else begin
            w_dly--; w_seen = 1; w_seen_v = m_wdata;
          end
        end else w_seen = 0;
        if (aw_have && w_have) begin
          wlog.push_back({aw_q, w_q});
          b_q = (cfg_err_en && aw_q == cfg_err_addr) ? 2'b10 : 2'b00;
          if (b_q == 2'b00) slave_write(aw_q, w_q);
          b_pend = 1; aw_have = 0; w_have = 0;
        end
        m_arready = 0;
        if (m_arvalid) begin
          if (r_pend) viol++;
          if (ar_dly == 0) begin
            m_arready = 1; rlog.push_back(m_araddr);
            r_q = slave_read(m_araddr); r_pend = 1; ar_dly = rnd_dly();
          end else ar_dly--;
        end
      end
    end
  end

  // ---------------- job runner ----------------
  task automatic run_job(input string nm, input logic [255:0] key, input logic [127:0] din,
                         input logic [31:0] mode, input int done_on, input int err_widx,
                         input int dly, input int hold);
    logic [63:0]  ew[$];
    logic [31:0]  er[$];
    logic [127:0] exp_d;
    logic [1:0]   exp_e;
    int           nw, npoll;
    bit           timeout;
    ew.delete(); er.delete();
    nw = (err_widx >= 0) ? err_widx + 1 : 14;
    for (int k = 0; k < nw; k++) begin
      if (k == 0)       ew.push_back({BASE + 32'h08, mode});
      else if (k <= 8)  ew.push_back({BASE + 32'h0C + 32'(4*(k-1)), key[32*(k-1) +: 32]});
      else if (k <= 12) ew.push_back({BASE + 32'h40 + 32'(4*(k-9)), din[32*(k-9) +: 32]});
      else              ew.push_back({BASE, 32'h1});
    end
    ew.push_back({BASE, 32'h0});
    timeout = !(done_on >= 1 && done_on <= PMAX);
    exp_d = '0;
    if (err_widx >= 0) exp_e = 2'b01;
    else begin
      npoll = timeout ? PMAX : done_on;
      for (int p = 0; p < npoll; p++) er.push_back(BASE + 32'h04);
      if (timeout) exp_e = 2'b10;
      else begin
        exp_e = 2'b00;
        for (int i = 0; i < 4; i++) begin
          er.push_back(BASE + 32'h80 + 32'(4*i));
          exp_d[32*i +: 32] = din[32*i +: 32] ^ key[32*i +: 32] ^ key[32*(i+4) +: 32] ^ mode;
        end
      end
    end

    cfg_done_on = done_on; cfg_dly_max = dly;
    cfg_err_en = (err_widx >= 0);
    cfg_err_addr = (err_widx >= 0) ? ew[err_widx][63:32] : 32'h0;
    wlog.delete(); rlog.delete(); viol = 0; s_status_rds = 0;

    @(negedge clk);
    chk({nm, "/cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1; cmd_key = key; cmd_data = din; cmd_mode = mode;
    @(negedge clk);
    cmd_valid = 0; cmd_key = ~key; cmd_data = ~din; cmd_mode = ~mode;
    chk({nm, "/cmd_ready_busy"}, cmd_ready, 0);
    for (int c = 0; c < 3000 && !rsp_valid; c++) @(negedge clk);
    if (!rsp_valid) begin
      chk({nm, "/rsp_wait"}, 0, 1);
      return;
    end
    for (int c = 0; c < hold; c++) begin
      chk($sformatf("%s/hold%0d_valid", nm, c), rsp_valid, 1);
      chk($sformatf("%s/hold%0d_data", nm, c), rsp_data, exp_d);
      chk($sformatf("%s/hold%0d_err", nm, c), rsp_err, exp_e);
      chk($sformatf("%s/hold%0d_cmd_ready", nm, c), cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    chk({nm, "/rsp_data"}, rsp_data, exp_d);
    chk({nm, "/rsp_err"}, rsp_err, exp_e);
    chk({nm, "/cmd_ready_at_rsp"}, cmd_ready, 0);
    @(negedge clk);
    rsp_ready = 0;
    chk({nm, "/rsp_valid_after"}, rsp_valid, 0);
    chk({nm, "/cmd_ready_after"}, cmd_ready, 1);
    chk({nm, "/n_writes"}, wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      chk($sformatf("%s/wr%0d", nm, i), wlog[i], ew[i]);
    chk({nm, "/n_reads"}, rlog.size(), er.size());
    for (int i = 0; i < er.size() && i < rlog.size(); i++)
      chk($sformatf("%s/rd%0d", nm, i), rlog[i], er[i]);
    chk({nm, "/protocol"}, viol, 0);
  endtask

  task automatic reset_in_poll();
    cfg_done_on = 0; cfg_err_en = 0; cfg_dly_max = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_key = '1; cmd_data = '1; cmd_mode = 32'h5;
    @(negedge clk);
    cmd_valid = 0;
    for (int c = 0; c < 500 && !m_arvalid; c++) @(negedge clk);
    chk("rst/arvalid_seen", m_arvalid, 1);
    resetn = 0;
    slave_clear();
    @(posedge clk);
    #1;
    chk("rst/m_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("rst/cmd_ready", cmd_ready, 1);
    chk("rst/rsp_valid", rsp_valid, 0);
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    logic [255:0] k;
    logic [127:0] d;
    logic [31:0]  md;
    cmd_valid = 0; cmd_key = '0; cmd_data = '0; cmd_mode = '0; rsp_ready = 0;
    cfg_done_on = 0; cfg_dly_max = 0; cfg_err_en = 0; cfg_err_addr = 0;
    s_mode = 0; s_status_rds = 0; viol = 0;
    for (int i = 0; i < 8; i++) s_key[i] = 0;
    for (int i = 0; i < 4; i++) s_din[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset/valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 0);
    chk("reset/cmd_ready", cmd_ready, 1);
    chk("reset/rsp", {rsp_data, rsp_err}, 0);
    chk("reset/addr_data", {m_awaddr, m_wdata, m_araddr}, 0);
    resetn = 1;

    for (int i = 0; i < 8; i++) k[32*i +: 32] = 32'h00010203 + 32'(i);
    d = 128'h00112233_44556677_8899aabb_ccddeeff;
    md = 32'h2;
    run_job("t1_zero_wait", k, d, md, 3, -1, 0, 0);
    run_job("t2_delayed", k, d, md, 3, -1, 5, 0);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom();
      md = $urandom();
      run_job($sformatf("t2_rand%0d", j), k, d, md, int'($urandom_range(PMAX, 1)), -1, 5, 0);
    end
    run_job("t3_bresp_key3", k, d, md, 3, 4, 0, 0);
    run_job("t4_timeout", k, d, md, 0, -1, 2, 0);
    reset_in_poll();
    run_job("t6_hold", k, d, md, 2, -1, 3, 10);
    run_job("t6_after", ~k, ~d, ~md, 1, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
